// File: rtl/pic_pkg.sv
// Shared widths, opcode match constants and sequencer state encoding for the
// PIC-style program counter sequencer and its call stack.
package pic_pkg;

  localparam int PC_W        = 11;
  localparam int INSTR_W     = 14;
  localparam int STACK_DEPTH = 8;
  localparam int SP_W        = 3;
  localparam int CNT_W       = 4;

  localparam logic [2:0]         OP_GOTO   = 3'b101;
  localparam logic [2:0]         OP_CALL   = 3'b100;
  localparam logic [3:0]         OP_RETLW  = 4'b1101;
  localparam logic [INSTR_W-1:0] OP_RETURN = 14'h0008;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_GOTO = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_t;

  // Classifies the latched instruction into the control-flow class it triggers.
  function automatic br_t decode_branch(input logic [INSTR_W-1:0] ins);
    br_t br;
    br = BR_NONE;
    if (ins[13:11] == OP_GOTO) begin
      br = BR_GOTO;
    end else if (ins[13:11] == OP_CALL) begin
      br = BR_CALL;
    end else if ((ins == OP_RETURN) || (ins[13:10] == OP_RETLW)) begin
      br = BR_RET;
    end
    return br;
  endfunction

endpackage

// File: rtl/call_stack.sv
// Circular 8-entry return-address stack with occupancy count; overflow/underflow
// are single-cycle pulses. Pop data is combinational, updates land on the clock edge.
module call_stack
  import pic_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] din_i,
  output logic [PC_W-1:0] dout_o,
  output logic            ovf_o,
  output logic            unf_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

  logic [PC_W-1:0]  mem_q [STACK_DEPTH];
  logic [SP_W-1:0]  ptr_q;
  logic [SP_W-1:0]  ptr_d;
  logic [SP_W-1:0]  rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full;
  logic             empty;

  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign rd_ptr = ptr_q - 3'd1;
  assign dout_o = mem_q[rd_ptr];
  assign ovf_o  = push_i && full;
  assign unf_o  = pop_i && empty;

  // Count saturates at both ends while the pointer keeps wrapping, so an
  // overflowing push replaces the oldest entry and an underflowing pop still
  // walks backwards through stale contents.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + 3'd1;
      if (!full) begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (pop_i) begin
      ptr_d = rd_ptr;
      if (!empty) begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: two cycles per instruction (FETCH latches ir, EXEC
// resolves the next pc); run is a level enable checked in IDLE and at EXEC end.
module pc_sequencer
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [PC_W-1:0]    rom_addr,
  input  logic               skip,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic               stk_ovf,
  output logic               stk_unf,
  output logic               busy
);

  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    pc_inc;
  logic [INSTR_W-1:0] ir_q;
  logic               ir_valid_q;
  logic               busy_q;
  logic               stk_ovf_q;
  logic               stk_unf_q;

  br_t                br;
  logic               in_exec;
  logic               stk_push;
  logic               stk_pop;
  logic [PC_W-1:0]    stk_dout;
  logic               stk_ovf_p;
  logic               stk_unf_p;

  assign pc_inc   = pc_q + 11'd1;
  assign br       = decode_branch(ir_q);
  assign in_exec  = (state_q == EXEC);
  assign stk_push = in_exec && (br == BR_CALL);
  assign stk_pop  = in_exec && (br == BR_RET);

  assign rom_addr = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign busy     = busy_q;
  assign stk_ovf  = stk_ovf_q;
  assign stk_unf  = stk_unf_q;

  // pc already points past the executing instruction, so CALL pushes it as-is
  // and a skip only needs one more increment.
  always_comb begin
    pc_d = pc_q;
    unique case (br)
      BR_GOTO, BR_CALL: pc_d = ir_q[PC_W-1:0];
      BR_RET:           pc_d = stk_dout;
      default:          pc_d = skip ? pc_inc : pc_q;
    endcase
  end

  call_stack u_call_stack (
    .clk    (clk),
    .rst    (rst),
    .push_i (stk_push),
    .pop_i  (stk_pop),
    .din_i  (pc_q),
    .dout_o (stk_dout),
    .ovf_o  (stk_ovf_p),
    .unf_o  (stk_unf_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      stk_ovf_q  <= 1'b0;
      stk_unf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          ir_q       <= rom_data;
          pc_q       <= pc_inc;
          ir_valid_q <= 1'b1;
          state_q    <= EXEC;
        end
        EXEC: begin
          pc_q       <= pc_d;
          ir_valid_q <= 1'b0;
          if (run) begin
            state_q <= FETCH;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          ir_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
      if (stk_ovf_p) begin
        stk_ovf_q <= 1'b1;
      end
      if (stk_unf_p) begin
        stk_unf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: an instruction-level reference model predicts every executed
// instruction; a negedge monitor compares each EXEC cycle against the queue.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        skip;
  logic [13:0] rom_data;
  logic [10:0] rom_addr;
  logic [13:0] ir;
  logic        ir_valid;
  logic        stk_ovf;
  logic        stk_unf;
  logic        busy;

  logic [13:0] rom [2048];
  bit          skip_at [2048];

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .skip     (skip),
    .ir       (ir),
    .ir_valid (ir_valid),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf),
    .busy     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_exec  = 0;

  typedef struct {
    logic [13:0] ir;
    logic [10:0] addr_exec;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        exp_q [$];
  int          trace [$];

  // Reference model state: address of the next instruction, return stack, flags.
  logic [10:0] m_pc;
  logic [10:0] m_mem [8];
  int          m_ptr;
  int          m_cnt;
  logic        m_ovf;
  logic        m_unf;

  bit          skip_rand;
  bit          run_rand;

  int exp_a [11] = '{0, 1, 2, 5, 3, 16, 4, 5, 3, 16, 4};
  int exp_c [9]  = '{0, 1, 2, 4, 2046, 0, 1, 2, 4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_trace(input string name, input int idx, input int val);
    logic [31:0] got;
    got = (idx < trace.size()) ? trace[idx] : 32'hFFFF_FFFF;
    check($sformatf("%s[%0d]", name, idx), got, val);
  endtask

  function automatic void push_expected();
    exp_t e;
    e.ir        = rom[m_pc];
    e.addr_exec = m_pc + 11'd1;
    e.ovf       = m_ovf;
    e.unf       = m_unf;
    exp_q.push_back(e);
  endfunction

  function automatic void model_step(input bit s);
    logic [13:0] w;
    logic [10:0] nxt;
    w   = rom[m_pc];
    nxt = m_pc + 11'd1;
    if (w[13:11] == 3'b101) begin
      m_pc = w[10:0];
    end else if (w[13:11] == 3'b100) begin
      m_mem[m_ptr] = nxt;
      m_ptr = (m_ptr + 1) % 8;
      if (m_cnt == 8) m_ovf = 1'b1;
      else m_cnt++;
      m_pc = w[10:0];
    end else if (w == 14'h0008 || w[13:10] == 4'b1101) begin
      m_ptr = (m_ptr + 7) % 8;
      m_pc = m_mem[m_ptr];
      if (m_cnt == 0) m_unf = 1'b1;
      else m_cnt--;
    end else begin
      m_pc = s ? nxt + 11'd1 : nxt;
    end
    push_expected();
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0) begin
      if (ir_valid) begin
        check("exp_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ir", ir, e.ir);
          check("exec_rom_addr", rom_addr, e.addr_exec);
          check("stk_ovf", stk_ovf, e.ovf);
          check("stk_unf", stk_unf, e.unf);
          check("busy_exec", busy, 1);
          n_exec++;
        end
      end else if (busy) begin
        trace.push_back(int'(rom_addr));
      end
    end
  end

  task automatic step_cycle();
    bit s;
    @(posedge clk);
    #1;
    if (run_rand) run = ($urandom_range(0, 9) < 8);
    if (ir_valid) begin
      s = skip_rand ? bit'($urandom_range(0, 1)) : skip_at[m_pc];
      skip = s;
      model_step(s);
    end else begin
      skip = skip_rand ? $urandom_range(0, 1) : 1'b0;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic run_until_exec(input int limit);
    int i;
    i = 0;
    do begin
      step_cycle();
      i++;
    end while (!ir_valid && i < limit);
    check("exec_reached", ir_valid, 1);
  endtask

  // Callers sit just after a rising edge, so reset can land mid-instruction.
  task automatic do_reset();
    rst  = 1'b1;
    run  = 1'b0;
    skip = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rom_addr", rom_addr, 0);
    check("rst_ir", ir, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", stk_ovf, 0);
    check("rst_unf", stk_unf, 0);
    exp_q.delete();
    trace.delete();
    m_pc  = '0;
    m_ptr = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    push_expected();
    rst = 1'b0;
    run = 1'b1;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 2048; a++) begin
      rom[a]     = 14'h0000;
      skip_at[a] = 1'b0;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [10:0] held_pc;
    rst       = 1'b1;
    run       = 1'b0;
    skip      = 1'b0;
    skip_rand = 1'b0;
    run_rand  = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;

    // Straight-line fetch timing, GOTO, CALL/RETURN round trip.
    clear_rom();
    rom[0]     = 14'h3044;
    rom[1]     = 14'h3E01;
    rom[2]     = 14'h2805;
    rom[3]     = 14'h2010;
    rom[5]     = 14'h2803;
    rom[11'h10] = 14'h0008;
    do_reset();
    run_cycles(2);
    check("c2_ir_valid", ir_valid, 1);
    check("c2_ir", ir, 14'h3044);
    run_cycles(1);
    check("c3_rom_addr", rom_addr, 1);
    run_cycles(1);
    check("c4_ir", ir, 14'h3E01);
    run_cycles(24);
    for (int i = 0; i < 11; i++) check_trace("trace_a", i, exp_a[i]);
    check("a_ovf", stk_ovf, 0);
    check("a_unf", stk_unf, 0);

    // Nine nested CALLs, then RETURNs unwinding into an underflow.
    clear_rom();
    for (int k = 0; k < 9; k++) begin
      rom[k * 64]     = {3'b100, 11'((k + 1) * 64)};
      rom[k * 64 + 1] = 14'h0008;
    end
    rom[9 * 64] = 14'h0008;
    do_reset();
    run_cycles(17);
    check("ovf_after_8_calls", stk_ovf, 0);
    run_cycles(2);
    check("ovf_after_9_calls", stk_ovf, 1);
    check("unf_during_calls", stk_unf, 0);
    run_cycles(60);
    for (int k = 0; k < 10; k++) check_trace("trace_call", k, k * 64);
    for (int j = 0; j < 8; j++) check_trace("trace_ret", 10 + j, (8 - j) * 64 + 1);
    check_trace("trace_unf", 18, 8 * 64 + 1);
    check("unf_sticky", stk_unf, 1);
    check("ovf_sticky", stk_ovf, 1);

    // Skip at address 2 and at 0x7FE, then run dropped mid-EXEC.
    clear_rom();
    rom[4]          = {3'b101, 11'h7FE};
    skip_at[2]      = 1'b1;
    skip_at[11'h7FE] = 1'b1;
    do_reset();
    run_cycles(20);
    for (int i = 0; i < 9; i++) check_trace("trace_skip", i, exp_c[i]);
    run_until_exec(10);
    held_pc = m_pc;
    run = 1'b0;
    run_cycles(1);
    check("stop_busy", busy, 0);
    check("stop_ir_valid", ir_valid, 0);
    check("stop_pc", rom_addr, held_pc);
    run_cycles(4);
    check("idle_pc_held", rom_addr, held_pc);
    check("idle_busy", busy, 0);
    run = 1'b1;
    run_cycles(12);

    // Random programs with random run/skip; each round ends with a reset mid-EXEC.
    skip_rand = 1'b1;
    run_rand  = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 2048; a++) begin
        case ($urandom_range(0, 11))
          0, 1:    rom[a] = {3'b101, 11'($urandom_range(0, 2047))};
          2:       rom[a] = {3'b100, 11'($urandom_range(0, 2047))};
          3:       rom[a] = 14'h0008;
          4:       rom[a] = {4'b1101, 10'($urandom_range(0, 1023))};
          default: rom[a] = 14'($urandom_range(0, 16383));
        endcase
      end
      do_reset();
      run_cycles(600);
      run_until_exec(50);
    end
    skip_rand = 1'b0;
    run_rand  = 1'b0;
    do_reset();
    run_cycles(4);

    check("exec_activity", n_exec >= 1000, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
